// File: rtl/apb4_req_master_if.sv
// Request/response port plus APB4 master bus for apb4_req_master.
// master = bridge side, slave = requester/APB-slave side.
interface apb4_req_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [SW-1:0]         req_strb_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_tout_o;

  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [2:0]            pprot_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [SW-1:0]         pstrb_o;
  logic                  pready_i;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pslverr_i;

  modport master (
    input  req_valid_i, req_write_i,
    input  req_addr_i, req_wdata_i,
    input  req_strb_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o,
    output rsp_err_o, rsp_tout_o,
    input  rsp_ready_i,
    output paddr_o, pprot_o, psel_o,
    output penable_o, pwrite_o,
    output pwdata_o, pstrb_o,
    input  pready_i, prdata_i,
    input  pslverr_i
  );

  modport slave (
    output req_valid_i, req_write_i,
    output req_addr_i, req_wdata_i,
    output req_strb_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o,
    input  rsp_err_o, rsp_tout_o,
    output rsp_ready_i,
    input  paddr_o, pprot_o, psel_o,
    input  penable_o, pwrite_o,
    input  pwdata_o, pstrb_o,
    output pready_i, prdata_i,
    output pslverr_i
  );
endinterface

// File: rtl/apb4_req_master.sv
// Valid/ready request port to APB4 master bridge, one transfer at a time.
// SETUP/ACCESS sequencing, PREADY wait states, optional access timeout.
module apb4_req_master #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         TIMEOUT    = 1024,
  parameter logic [2:0] PROT       = 3'b000
) (
  input logic               clk_i,
  input logic               rst_n_i,
  apb4_req_master_if.master bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int AL = (SW > 1) ? $clog2(SW) : 0;
  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    {ADDR_WIDTH{1'b1}} << AL;
  localparam logic [CW-1:0] TMAX =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [SW-1:0]         pstrb_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rerr_q;
  logic                  rtout_q;

  logic accept;
  logic done;
  logic expire;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        accept = bus.req_valid_i;
        if (bus.req_valid_i) state_d = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        done   = bus.pready_i;
        expire = TO_EN && !bus.pready_i &&
                 (cnt_q == TMAX);
        if (done || expire) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      rtout_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      // APB strobes are flops keyed off next state
      psel_q    <= (state_d == SETUP) ||
                   (state_d == ACCESS);
      penable_q <= (state_d == ACCESS);
      rvalid_q  <= (state_d == RESP);

      if (accept) begin
        paddr_q  <= bus.req_addr_i & AMASK;
        pwrite_q <= bus.req_write_i;
        pwdata_q <= bus.req_write_i ?
                    bus.req_wdata_i : '0;
        pstrb_q  <= bus.req_write_i ?
                    bus.req_strb_i : '0;
      end

      if (state_d == SETUP)
        cnt_q <= '0;
      else if (TO_EN && state_q == ACCESS &&
               !bus.pready_i && !expire)
        cnt_q <= cnt_q + CW'(1);

      if (done) begin
        rdata_q <= pwrite_q ? '0 : bus.prdata_i;
        rerr_q  <= bus.pslverr_i;
        rtout_q <= 1'b0;
      end else if (expire) begin
        rdata_q <= '0;
        rerr_q  <= 1'b1;
        rtout_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = rvalid_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = rerr_q;
  assign bus.rsp_tout_o  = rtout_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pprot_o     = PROT;
  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.pwdata_o    = pwdata_q;
  assign bus.pstrb_o     = pstrb_q;
endmodule

// File: tb/tb_apb4_req_master.sv
// Directed bench for apb4_req_master (TIMEOUT=8).
// Samples 1ns after each rising edge, drives right after.
module tb_apb4_req_master;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  apb4_req_master_if #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) bus ();

  apb4_req_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT(8),
    .PROT(3'b010)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic req(input logic w,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] s);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = w;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    bus.req_strb_i  = s;
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_strb_i  = '0;
    bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b0;
    bus.prdata_i    = '0;
    bus.pslverr_i   = 1'b0;

    tick();
    tick();
    chk("rst_psel", bus.psel_o, 0);
    chk("rst_pen", bus.penable_o, 0);
    chk("rst_rvalid", bus.rsp_valid_o, 0);
    chk("rst_paddr", bus.paddr_o, 0);
    chk("rst_ready", bus.req_ready_o, 1);
    chk("pprot", bus.pprot_o, 3'b010);
    rst_n_i = 1'b1;
    tick();

    // 1: zero-wait write, address low bits cleared
    req(1, 32'h13, 32'hDEADBEEF, 4'hF);
    bus.pready_i = 1'b1;
    chk("t1_ready", bus.req_ready_o, 1);
    tick();
    bus.req_valid_i = 1'b0;
    chk("t1_setup_sel", bus.psel_o, 1);
    chk("t1_setup_en", bus.penable_o, 0);
    chk("t1_paddr", bus.paddr_o, 32'h10);
    chk("t1_pwrite", bus.pwrite_o, 1);
    chk("t1_pwdata", bus.pwdata_o, 32'hDEADBEEF);
    chk("t1_pstrb", bus.pstrb_o, 4'hF);
    chk("t1_nready", bus.req_ready_o, 0);
    tick();
    chk("t1_acc_sel", bus.psel_o, 1);
    chk("t1_acc_en", bus.penable_o, 1);
    chk("t1_acc_rv", bus.rsp_valid_o, 0);
    tick();
    chk("t1_rvalid", bus.rsp_valid_o, 1);
    chk("t1_psel0", bus.psel_o, 0);
    chk("t1_pen0", bus.penable_o, 0);
    chk("t1_err", bus.rsp_err_o, 0);
    chk("t1_tout", bus.rsp_tout_o, 0);
    chk("t1_rdata", bus.rsp_rdata_o, 0);
    bus.pready_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("t1_idle_rv", bus.rsp_valid_o, 0);
    chk("t1_idle_rdy", bus.req_ready_o, 1);

    // 2: read with 3 wait states
    req(0, 32'h04, 32'hFFFFFFFF, 4'hF);
    bus.prdata_i = 32'h12345678;
    tick();
    bus.req_valid_i = 1'b0;
    chk("t2_pwrite", bus.pwrite_o, 0);
    chk("t2_pstrb", bus.pstrb_o, 0);
    chk("t2_pwdata", bus.pwdata_o, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_sel", bus.psel_o, 1);
      chk("t2_en", bus.penable_o, 1);
      chk("t2_paddr", bus.paddr_o, 32'h04);
      chk("t2_pstrb_acc", bus.pstrb_o, 0);
      chk("t2_rv_wait", bus.rsp_valid_o, 0);
      if (i == 3) bus.pready_i = 1'b1;
      tick();
    end
    bus.pready_i = 1'b0;
    bus.prdata_i = 32'h0BADF00D;
    chk("t2_rvalid", bus.rsp_valid_o, 1);
    chk("t2_rdata", bus.rsp_rdata_o, 32'h12345678);
    chk("t2_err", bus.rsp_err_o, 0);

    // 5: response stall; pending request must wait
    req(1, 32'h22, 32'hA5A5A5A5, 4'h3);
    for (int i = 0; i < 5; i++) begin
      chk("t5_rv", bus.rsp_valid_o, 1);
      chk("t5_rdata", bus.rsp_rdata_o,
          32'h12345678);
      chk("t5_nready", bus.req_ready_o, 0);
      chk("t5_psel", bus.psel_o, 0);
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("t5_idle_rdy", bus.req_ready_o, 1);
    chk("t5_idle_rv", bus.rsp_valid_o, 0);
    chk("t5_idle_sel", bus.psel_o, 0);
    tick();
    bus.req_valid_i = 1'b0;
    chk("t5_setup_sel", bus.psel_o, 1);
    chk("t5_paddr", bus.paddr_o, 32'h20);
    chk("t5_pstrb", bus.pstrb_o, 4'h3);

    // 3: write completing with PSLVERR
    tick();
    bus.pready_i  = 1'b1;
    bus.pslverr_i = 1'b1;
    bus.prdata_i  = 32'hFFFFFFFF;
    tick();
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b0;
    chk("t3_rv", bus.rsp_valid_o, 1);
    chk("t3_err", bus.rsp_err_o, 1);
    chk("t3_tout", bus.rsp_tout_o, 0);
    chk("t3_rdata", bus.rsp_rdata_o, 0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;

    // 4: timeout after 8 ACCESS cycles
    req(0, 32'h08, 32'h0, 4'h0);
    bus.prdata_i = 32'h55AA55AA;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t4_sel", bus.psel_o, 1);
      chk("t4_en", bus.penable_o, 1);
      tick();
    end
    chk("t4_psel0", bus.psel_o, 0);
    chk("t4_rv", bus.rsp_valid_o, 1);
    chk("t4_err", bus.rsp_err_o, 1);
    chk("t4_tout", bus.rsp_tout_o, 1);
    chk("t4_rdata", bus.rsp_rdata_o, 0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;

    // PREADY on the last allowed cycle wins
    req(0, 32'h0C, 32'h0, 4'h0);
    bus.prdata_i = 32'hCAFEF00D;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t4b_sel", bus.psel_o, 1);
      if (i == 7) bus.pready_i = 1'b1;
      tick();
    end
    bus.pready_i = 1'b0;
    chk("t4b_rv", bus.rsp_valid_o, 1);
    chk("t4b_err", bus.rsp_err_o, 0);
    chk("t4b_tout", bus.rsp_tout_o, 0);
    chk("t4b_rdata", bus.rsp_rdata_o,
        32'hCAFEF00D);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;

    // 6: async reset during ACCESS
    req(1, 32'h30, 32'h11223344, 4'hF);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    chk("t6_en", bus.penable_o, 1);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("t6_sel0", bus.psel_o, 0);
    chk("t6_en0", bus.penable_o, 0);
    chk("t6_rv0", bus.rsp_valid_o, 0);
    chk("t6_paddr0", bus.paddr_o, 0);
    tick();
    rst_n_i = 1'b1;
    tick();
    chk("t6_rdy", bus.req_ready_o, 1);
    chk("t6_sel", bus.psel_o, 0);
    chk("t6_rv", bus.rsp_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
